// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one read/write command per frame,
// serialised onto MDC with split o/t/i MDIO signals (t=1 releases the bus).
module mdio_master #(
   parameter int CLK_DIV     = 4,
   parameter bit PREAMBLE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdio_mdc,
   output logic        mdio_o,
   output logic        mdio_t,
   input  logic        mdio_i
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ST_OP,
      S_ADDR,
      S_TA,
      S_DATA,
      S_END
   } state_t;

   state_t         state, state_nxt;
   logic [DW-1:0]  div_cnt;
   logic           half;
   logic [5:0]     bit_cnt;
   logic [31:0]    sr, sr_nxt;
   logic           wr, wr_nxt;
   logic [15:0]    rd_sr;
   logic           err_s;
   logic           o_nxt, t_nxt;
   logic           accept, tick, rise, bit_end;

   assign accept    = (state == S_IDLE) && cmd_valid;
   assign tick      = (div_cnt == DIV_LAST);
   assign rise      = (state != S_IDLE) && tick && !half;
   assign bit_end   = (state != S_IDLE) && tick && half;
   assign cmd_ready = (state == S_IDLE);
   assign busy      = ~cmd_ready;
   assign rsp_valid = (state == S_END) && bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_nxt    = wr;
      sr_nxt    = sr;
      o_nxt     = 1'b1;
      t_nxt     = 1'b1;
      if (accept) begin
         wr_nxt = cmd_write;
         sr_nxt = {2'b01, (cmd_write ? 2'b01 : 2'b10),
                   cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata};
      end else if (bit_end && state != S_PRE) begin
         sr_nxt = {sr[30:0], 1'b0};
      end
      unique case (state)
         S_IDLE:  if (cmd_valid)
                     state_nxt = PREAMBLE_EN ? S_PRE : S_ST_OP;
         S_PRE:   if (bit_end && bit_cnt == 6'd31) state_nxt = S_ST_OP;
         S_ST_OP: if (bit_end && bit_cnt == 6'd35) state_nxt = S_ADDR;
         S_ADDR:  if (bit_end && bit_cnt == 6'd45) state_nxt = S_TA;
         S_TA:    if (bit_end && bit_cnt == 6'd47) state_nxt = S_DATA;
         S_DATA:  if (bit_end && bit_cnt == 6'd63) state_nxt = S_END;
         S_END:   if (bit_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Pin values for the bit whose low phase starts next cycle
      unique case (state_nxt)
         S_PRE: begin
            o_nxt = 1'b1;
            t_nxt = 1'b0;
         end
         S_ST_OP, S_ADDR: begin
            o_nxt = sr_nxt[31];
            t_nxt = 1'b0;
         end
         S_TA, S_DATA: begin
            o_nxt = wr_nxt ? sr_nxt[31] : 1'b1;
            t_nxt = ~wr_nxt;
         end
         default: begin
            o_nxt = 1'b1;
            t_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         half      <= 1'b0;
         bit_cnt   <= '0;
         sr        <= '0;
         wr        <= 1'b0;
         rd_sr     <= '0;
         err_s     <= 1'b0;
         mdio_mdc  <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_t    <= 1'b1;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         sr <= sr_nxt;
         wr <= wr_nxt;
         if (accept) begin
            div_cnt  <= '0;
            half     <= 1'b0;
            bit_cnt  <= PREAMBLE_EN ? 6'd0 : 6'd32;
            mdio_mdc <= 1'b0;
            mdio_o   <= o_nxt;
            mdio_t   <= t_nxt;
         end else if (state != S_IDLE) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) half <= ~half;
            if (rise) begin
               // END is an idle bit: keep MDC low through it
               mdio_mdc <= (state != S_END);
               if (state == S_TA && bit_cnt == 6'd47) err_s <= mdio_i;
               if (state == S_DATA) rd_sr <= {rd_sr[14:0], mdio_i};
            end
            if (bit_end) begin
               mdio_mdc <= 1'b0;
               mdio_o   <= o_nxt;
               mdio_t   <= t_nxt;
               if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
               if (state == S_DATA && bit_cnt == 6'd63) begin
                  rsp_err <= ~wr & err_s;
                  if (!wr) rsp_rdata <= rd_sr;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised bench for mdio_master: a bit-level frame model predicts
// MDC/MDIO, handshake and response outputs every cycle.
module tb_mdio_master;

   localparam int D  = 4;
   localparam int BP = 2 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [4:0]  pa = '0;
   logic [4:0]  ra = '0;
   logic [15:0] wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err, busy;
   logic [15:0] rsp_rdata;
   logic        mdc, mo, mt;
   logic        mi = 1'b1;

   logic        c1_valid = 1'b0;
   logic        c1_ready, rv1, err1, busy1, mdc1, mo1, mt1;
   logic [15:0] rdata1;
   logic        mi1;

   assign mi1 = 1'b1;

   always #5 clk = ~clk;

   mdio_master #(.CLK_DIV(D), .PREAMBLE_EN(1'b1)) u0 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_phy_addr(pa), .cmd_reg_addr(ra),
      .cmd_wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .mdio_mdc(mdc), .mdio_o(mo), .mdio_t(mt), .mdio_i(mi)
   );

   mdio_master #(.CLK_DIV(D), .PREAMBLE_EN(1'b0)) u1 (
      .clk(clk), .rst(rst),
      .cmd_valid(c1_valid), .cmd_ready(c1_ready),
      .cmd_write(1'b0), .cmd_phy_addr(5'd3), .cmd_reg_addr(5'd2),
      .cmd_wdata(16'h0),
      .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1),
      .busy(busy1), .mdio_mdc(mdc1), .mdio_o(mo1), .mdio_t(mt1), .mdio_i(mi1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // Frame model: k = cycle index within the current frame (0 = idle)
   int          k = 0;
   int          tot = 0;
   int          acc_cnt = 0;
   bit          eo[65];
   bit          et[65];
   bit          m_wr, m_pres, m_ta2;
   logic [15:0] m_data;
   bit          s_pres, s_ta2;
   logic [15:0] s_data;
   logic [15:0] exp_rdata = '0;

   always @(posedge clk or posedge rst) begin
      logic [31:0] word;
      if (rst) begin
         k = 0;
      end else if (k == 0) begin
         if (cmd_valid) begin
            m_wr = cmd_write;
            m_pres = s_pres;
            m_ta2 = s_ta2;
            m_data = s_data;
            word = {2'b01, (cmd_write ? 2'b01 : 2'b10), pa, ra, 2'b10, wdata};
            for (int i = 0; i < 32; i++) begin
               eo[i] = 1'b1;
               et[i] = 1'b0;
            end
            for (int j = 0; j < 32; j++) begin
               if (!cmd_write && j >= 14) begin
                  eo[32+j] = 1'b1;
                  et[32+j] = 1'b1;
               end else begin
                  eo[32+j] = word[31-j];
                  et[32+j] = 1'b0;
               end
            end
            eo[64] = 1'b1;
            et[64] = 1'b1;
            tot = 65 * BP;
            k = 1;
            acc_cnt++;
         end
      end else if (k == tot) begin
         k = 0;
      end else begin
         k++;
      end
   end

   logic [63:0] cap = '0;
   logic [63:0] cap_rv = '0;
   logic        pmdc = 1'b0;
   int          acc_obs = 0, rv_obs = 0, last_lat = 0, q_gap = 0;
   int          rv_count = 0;

   always @(negedge clk) begin
      int b, ph;
      bit e_mdc, e_o, e_t, e_rv;
      if (rst) exp_rdata = '0;
      b = 0;
      if (k == 0) begin
         e_mdc = 1'b0; e_o = 1'b1; e_t = 1'b1; e_rv = 1'b0;
      end else begin
         b = (k - 1) / BP;
         ph = (k - 1) % BP;
         e_mdc = (ph >= D) && (b < 64);
         e_o = eo[b];
         e_t = et[b];
         e_rv = (k == tot);
      end
      chk("mdc", mdc, e_mdc);
      chk("mdio_t", mt, e_t);
      if (!e_t || k == 0 || b == 64) chk("mdio_o", mo, e_o);
      chk("cmd_ready", cmd_ready, k == 0);
      chk("busy", busy, k != 0);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
         if (m_wr) begin
            chk("wr_rsp_err", rsp_err, 0);
            chk("wr_rsp_rdata", rsp_rdata, exp_rdata);
         end else begin
            exp_rdata = m_pres ? m_data : 16'hFFFF;
            chk("rd_rsp_rdata", rsp_rdata, exp_rdata);
            chk("rd_rsp_err", rsp_err, m_pres ? m_ta2 : 1'b1);
         end
      end
      if (cmd_valid && cmd_ready && !rst) begin
         acc_obs = cyc;
         q_gap = cyc - rv_obs;
         cap = '0;
      end
      if (mdc && !pmdc) cap = {cap[62:0], mo};
      if (rsp_valid) begin
         rv_obs = cyc;
         last_lat = cyc - acc_obs;
         cap_rv = cap;
         rv_count++;
      end
      pmdc = mdc;
      // PHY: drives TA bit 2 and DATA of reads, otherwise pull-up
      mi = 1'b1;
      if (k > 0 && !m_wr && m_pres) begin
         if (b == 47) mi = m_ta2;
         else if (b >= 48 && b <= 63) mi = m_data[63-b];
      end
   end

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(bit wr, logic [4:0] p, logic [4:0] r,
                        logic [15:0] d, bit pres, bit ta2, bit hold);
      int n0, t;
      n0 = acc_cnt;
      cmd_write = wr;
      pa = p;
      ra = r;
      wdata = d;
      s_pres = pres;
      s_ta2 = ta2;
      s_data = d;
      cmd_valid = 1'b1;
      t = 0;
      while (acc_cnt == n0 && t < 3000) begin
         tick1();
         t++;
      end
      chk("accepted", acc_cnt != n0, 1);
      if (!hold) begin
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom);
         pa = 5'($urandom);
         ra = 5'($urandom);
         wdata = 16'($urandom);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (k != 0 && t < 3000) begin
         tick1();
         t++;
      end
      chk("idle_reached", k == 0, 1);
   endtask

   initial begin
      int c0, t, tgt, acc1, lat1;
      logic [63:0] cap1;
      logic p1;
      bit wr, pres, hold;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rsp_rdata, 16'h0);
      chk("rst_err", rsp_err, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mdc", mdc, 0);
      chk("rst_o", mo, 1);
      chk("rst_t", mt, 1);
      chk("rst_rv", rsp_valid, 0);
      rst = 1'b0;
      tick1();

      issue(1, 5'd1, 5'd0, 16'h1140, 1, 0, 0);
      wait_idle();
      chk("wr_latency", last_lat, 520);
      chk("wr_frame", cap_rv, 64'hFFFF_FFFF_5082_1140);

      issue(0, 5'd3, 5'd2, 16'h796D, 1, 0, 0);
      wait_idle();
      chk("rd_data", rsp_rdata, 16'h796D);
      chk("rd_err", rsp_err, 0);
      chk("rd_latency", last_lat, 520);

      c0 = rv_count;
      issue(0, 5'd31, 5'd31, 16'h0000, 0, 0, 0);
      wait_idle();
      repeat (20) tick1();
      chk("nophy_data", rsp_rdata, 16'hFFFF);
      chk("nophy_err", rsp_err, 1);
      chk("nophy_pulses", rv_count - c0, 1);

      issue(1, 5'd2, 5'd4, 16'hA5A5, 1, 0, 1);
      issue(0, 5'd2, 5'd4, 16'h1234, 1, 1, 0);
      chk("queue_gap", q_gap, 1);
      wait_idle();
      chk("queue_rdata", rsp_rdata, 16'h1234);
      chk("queue_err", rsp_err, 1);

      for (int i = 0; i < 12; i++) begin
         wr = 1'($urandom);
         pres = ($urandom_range(0, 3) != 0);
         hold = (i < 11) && ($urandom_range(0, 3) == 0);
         issue(wr, 5'($urandom), 5'($urandom), 16'($urandom),
               pres, 1'($urandom), hold);
         if (!hold) begin
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 20)) tick1();
         end
      end
      wait_idle();

      c0 = rv_count;
      issue(1, 5'd7, 5'd9, 16'hBEEF, 1, 0, 0);
      tgt = 53 * BP + 6;
      t = 0;
      while (k != tgt && t < 3000) begin
         tick1();
         t++;
      end
      chk("data5_reached", k == tgt, 1);
      chk("data5_mdc_high", mdc, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_t", mt, 1);
      chk("rst_mid_mdc", mdc, 0);
      chk("rst_mid_rv", rsp_valid, 0);
      tick1();
      tick1();
      rst = 1'b0;
      tick1();
      chk("rst_mid_ready", cmd_ready, 1);
      chk("rst_mid_no_rsp", rv_count - c0, 0);
      issue(1, 5'd1, 5'd0, 16'h1140, 1, 0, 0);
      wait_idle();
      chk("post_rst_frame", cap_rv, 64'hFFFF_FFFF_5082_1140);
      chk("post_rst_latency", last_lat, 520);

      // Preamble-suppressed instance, no PHY attached
      c1_valid = 1'b1;
      t = 0;
      acc1 = -1;
      while (acc1 < 0 && t < 100) begin
         @(negedge clk);
         if (c1_ready) acc1 = cyc;
         t++;
      end
      chk("np_accepted", acc1 >= 0, 1);
      @(posedge clk);
      #1;
      c1_valid = 1'b0;
      @(negedge clk);
      chk("np_first_o", mo1, 0);
      chk("np_first_t", mt1, 0);
      cap1 = '0;
      p1 = mdc1;
      lat1 = -1;
      t = 0;
      while (lat1 < 0 && t < 1000) begin
         @(negedge clk);
         if (mdc1 && !p1) cap1 = {cap1[62:0], mo1};
         p1 = mdc1;
         if (rv1) lat1 = cyc - acc1;
         t++;
      end
      chk("np_latency", lat1, 264);
      chk("np_header", cap1[31:18], 14'h1862);
      chk("np_rdata", rdata1, 16'hFFFF);
      chk("np_err", err1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
